// File: rtl/pico_io_pkg.sv
// Shared constants and types for the KCPSM6 peripheral I/O bridge:
// port map, STATUS bit layout and the queued transaction format.
package pico_io_pkg;

   // OUTPUT (write) port map
   localparam logic [7:0] PORT_ADDR    = 8'h00;
   localparam logic [7:0] PORT_DATA    = 8'h01;
   localparam logic [7:0] PORT_CTRL    = 8'h02;
   localparam logic [3:0] KPORT_CTRL   = 4'h2;

   // INPUT (read) port map
   localparam logic [7:0] PORT_STATUS  = 8'h00;
   localparam logic [7:0] PORT_CTRL_RB = 8'h01;
   localparam logic [7:0] PORT_RESP    = 8'h02;
   localparam logic [7:0] PORT_ADDR_RB = 8'h03;

   // STATUS bit layout
   localparam int ST_EMPTY   = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_OVF     = 2;
   localparam int ST_CNT_LSB = 3;
   localparam int ST_CNT_MSB = 6;
   localparam int ST_VALID   = 7;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } txn_t;

   function automatic logic [7:0] pack_status(
      input logic       empty,
      input logic       full,
      input logic       ovf,
      input logic       valid,
      input logic [3:0] count
   );
      logic [7:0] s;
      s = '0;
      s[ST_EMPTY]                = empty;
      s[ST_FULL]                 = full;
      s[ST_OVF]                  = ovf;
      s[ST_CNT_MSB:ST_CNT_LSB]   = count;
      s[ST_VALID]                = valid;
      return s;
   endfunction

endpackage

// File: rtl/pico_io_bridge_if.sv
// Valid/ready peripheral bus carrying queued write transactions and
// returning one response byte per accepted transfer.
interface pico_io_bridge_if;
   logic [7:0] bus_addr;
   logic [7:0] bus_data;
   logic       bus_valid;
   logic       bus_ready;
   logic [7:0] bus_rdata;

   modport master (
      output bus_addr,
      output bus_data,
      output bus_valid,
      input  bus_ready,
      input  bus_rdata
   );

   modport slave (
      input  bus_addr,
      input  bus_data,
      input  bus_valid,
      output bus_ready,
      output bus_rdata
   );
endinterface

// File: rtl/pico_io_fifo.sv
// Small transaction FIFO: power-of-two depth, combinational head output,
// pushes refused while full even if a pop happens in the same cycle.
module pico_io_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;
   logic             push_ok;
   logic             pop_ok;
   logic [DEPTH-1:0] entry_we;

   assign full    = (count_reg == CNT_W'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_we
         assign entry_we[gi] = push_ok && (wr_ptr_reg == PTR_W'(gi));
      end
   endgenerate

   // Storage is not reset; the head is forced to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_we[i]) begin
            mem[i] <= wdata;
         end
      end
   end

   assign rdata = empty ? '0 : mem[rd_ptr_reg];

   always_comb begin
      count_next = count_reg;
      case ({push_ok, pop_ok})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/pico_io_bridge.sv
// KCPSM6 port decode to a queued valid/ready peripheral bus, with
// registered STATUS/control/response readback onto in_port.
module pico_io_bridge
   import pico_io_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       port_id,
   input  logic [7:0]       out_port,
   input  logic             write_strobe,
   input  logic             k_write_strobe,
   input  logic             read_strobe,
   output logic [7:0]       in_port,
   pico_io_bridge_if.master bus,
   output logic [7:0]       ctrl_reg
);

   logic [7:0]       addr_reg;
   logic [7:0]       resp_reg;
   logic             overflow_reg;
   logic [7:0]       rd_data_next;

   logic             wr_addr;
   logic             push;
   logic             wr_ctrl;
   logic             pop;
   logic             clr_ovf;
   txn_t             push_txn;
   txn_t             head_txn;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;

   assign wr_addr = write_strobe && (port_id == PORT_ADDR);
   assign push    = write_strobe && (port_id == PORT_DATA);
   // OUTPUTK only carries a 4-bit port address.
   assign wr_ctrl = (write_strobe && (port_id == PORT_CTRL)) ||
                    (k_write_strobe && (port_id[3:0] == KPORT_CTRL));
   assign clr_ovf = read_strobe && (port_id == PORT_STATUS);
   assign pop     = bus.bus_valid && bus.bus_ready;

   assign push_txn.addr = addr_reg;
   assign push_txn.data = out_port;

   pico_io_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (16),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (push_txn),
      .pop   (pop),
      .rdata (head_txn),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   assign bus.bus_valid = !empty;
   assign bus.bus_addr  = head_txn.addr;
   assign bus.bus_data  = head_txn.data;

   always_ff @(posedge clk) begin
      if (!reset) begin
         addr_reg     <= '0;
         ctrl_reg     <= '0;
         resp_reg     <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (wr_addr) begin
            addr_reg <= out_port;
         end
         if (wr_ctrl) begin
            ctrl_reg <= out_port;
         end
         if (pop) begin
            resp_reg <= bus.bus_rdata;
         end
         // A refused push in the same cycle as a clear keeps the flag set.
         if (push && full) begin
            overflow_reg <= 1'b1;
         end else if (clr_ovf) begin
            overflow_reg <= 1'b0;
         end
      end
   end

   always_comb begin
      rd_data_next = '0;
      case (port_id)
         PORT_STATUS:  rd_data_next = pack_status(empty, full, overflow_reg,
                                                  !empty, 4'(count));
         PORT_CTRL_RB: rd_data_next = ctrl_reg;
         PORT_RESP:    rd_data_next = resp_reg;
         PORT_ADDR_RB: rd_data_next = addr_reg;
         default:      rd_data_next = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         in_port <= '0;
      end else begin
         in_port <= rd_data_next;
      end
   end

endmodule

// File: tb/tb_pico_io_bridge.sv
// Scoreboard bench for pico_io_bridge: stimulus queues expected values,
// a negedge monitor compares register state and every bus transfer.
module tb_pico_io_bridge;

   localparam int K_INPORT = 0;
   localparam int K_VALID  = 1;
   localparam int K_CTRL   = 2;
   localparam int K_ADDR   = 3;
   localparam int K_DATA   = 4;

   typedef struct {
      int         kind;
      logic [7:0] exp;
      string      name;
   } chk_t;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
      string      name;
   } xfer_t;

   logic       clk;
   logic       reset;
   logic [7:0] port_id;
   logic [7:0] out_port;
   logic       write_strobe;
   logic       k_write_strobe;
   logic       read_strobe;
   logic [7:0] in_port;
   logic [7:0] ctrl_reg;

   pico_io_bridge_if bus ();

   pico_io_bridge #(
      .FIFO_DEPTH (4),
      .CNT_W      (5)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .port_id        (port_id),
      .out_port       (out_port),
      .write_strobe   (write_strobe),
      .k_write_strobe (k_write_strobe),
      .read_strobe    (read_strobe),
      .in_port        (in_port),
      .bus            (bus),
      .ctrl_reg       (ctrl_reg)
   );

   chk_t  chk_q  [$];
   xfer_t xfer_q [$];
   int    passed = 0;
   int    total  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act === exp) begin
         passed++;
         $display("check %-12s got %02h expected %02h ok", name, act, exp);
      end else begin
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   // Monitor: bus transfers and queued state checks, sampled on negedge.
   chk_t  mon_c;
   xfer_t mon_x;
   logic [7:0] mon_act;
   always @(negedge clk) begin
      if (bus.bus_valid === 1'b1 && bus.bus_ready === 1'b1) begin
         if (xfer_q.size() == 0) begin
            cmp("xfer_unexp", bus.bus_data, 8'hxx);
         end else begin
            mon_x = xfer_q.pop_front();
            cmp({mon_x.name, "_a"}, bus.bus_addr, mon_x.addr);
            cmp({mon_x.name, "_d"}, bus.bus_data, mon_x.data);
         end
      end
      while (chk_q.size() > 0) begin
         mon_c = chk_q.pop_front();
         case (mon_c.kind)
            K_INPORT: mon_act = in_port;
            K_VALID:  mon_act = {7'b0, bus.bus_valid};
            K_CTRL:   mon_act = ctrl_reg;
            K_ADDR:   mon_act = bus.bus_addr;
            default:  mon_act = bus.bus_data;
         endcase
         cmp(mon_c.name, mon_act, mon_c.exp);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_sig(input int kind, input logic [7:0] exp, input string name);
      chk_t c;
      c.kind = kind;
      c.exp  = exp;
      c.name = name;
      chk_q.push_back(c);
   endtask

   task automatic expect_xfer(input logic [7:0] a, input logic [7:0] d, input string name);
      xfer_t x;
      x.addr = a;
      x.data = d;
      x.name = name;
      xfer_q.push_back(x);
   endtask

   task automatic out_w(input logic [7:0] p, input logic [7:0] d);
      port_id      = p;
      out_port     = d;
      write_strobe = 1'b1;
      tick();
      write_strobe = 1'b0;
   endtask

   task automatic out_k(input logic [7:0] p, input logic [7:0] d);
      port_id        = p;
      out_port       = d;
      k_write_strobe = 1'b1;
      tick();
      k_write_strobe = 1'b0;
   endtask

   task automatic rd(input logic [7:0] p, input logic strobe, input logic [7:0] exp,
                     input string name);
      port_id     = p;
      read_strobe = strobe;
      tick();
      read_strobe = 1'b0;
      expect_sig(K_INPORT, exp, name);
   endtask

   task automatic pop_one(input logic [7:0] rdata, input logic [7:0] a,
                          input logic [7:0] d, input string name);
      expect_xfer(a, d, name);
      bus.bus_rdata = rdata;
      bus.bus_ready = 1'b1;
      tick();
      bus.bus_ready = 1'b0;
   endtask

   initial begin
      reset          = 1'b0;
      port_id        = 8'h00;
      out_port       = 8'h00;
      write_strobe   = 1'b0;
      k_write_strobe = 1'b0;
      read_strobe    = 1'b0;
      bus.bus_ready  = 1'b0;
      bus.bus_rdata  = 8'h00;
      repeat (3) tick();
      expect_sig(K_INPORT, 8'h00, "rst_inport");
      expect_sig(K_VALID,  8'h00, "rst_valid");
      expect_sig(K_CTRL,   8'h00, "rst_ctrl");
      expect_sig(K_ADDR,   8'h00, "rst_addr");
      expect_sig(K_DATA,   8'h00, "rst_data");
      reset = 1'b1;
      tick();
      rd(8'h00, 1'b0, 8'h01, "st_empty");

      // single push
      out_w(8'h00, 8'h3C);
      out_w(8'h01, 8'h5A);
      expect_sig(K_VALID, 8'h01, "push_valid");
      expect_sig(K_ADDR,  8'h3C, "push_addr");
      expect_sig(K_DATA,  8'h5A, "push_data");
      rd(8'h00, 1'b0, 8'h88, "st_one");
      rd(8'h03, 1'b0, 8'h3C, "addr_rb");

      // fill to full, fifth push refused
      out_w(8'h00, 8'h11);
      out_w(8'h01, 8'hA1);
      out_w(8'h01, 8'hA2);
      out_w(8'h01, 8'hA3);
      out_w(8'h01, 8'hA4);
      rd(8'h00, 1'b0, 8'hA6, "st_ovf");
      rd(8'h00, 1'b1, 8'hA6, "st_clr_rd");
      rd(8'h00, 1'b0, 8'hA2, "st_cleared");

      // pop from full, response capture, head advance
      pop_one(8'h77, 8'h3C, 8'h5A, "pop1");
      rd(8'h00, 1'b0, 8'h98, "st_cnt3");
      rd(8'h02, 1'b0, 8'h77, "resp");
      expect_sig(K_ADDR, 8'h11, "head_a");
      expect_sig(K_DATA, 8'hA1, "head_d");

      // control register via OUTPUTK and OUTPUT
      out_k(8'h12, 8'hE5);
      expect_sig(K_CTRL, 8'hE5, "k_ctrl");
      out_k(8'h13, 8'h44);
      expect_sig(K_CTRL, 8'hE5, "k_other");
      rd(8'h01, 1'b0, 8'hE5, "ctrl_rb");
      out_w(8'h07, 8'h99);
      rd(8'h00, 1'b0, 8'h98, "st_ignored");

      // simultaneous push and pop at count 2
      pop_one(8'h55, 8'h11, 8'hA1, "pop2");
      expect_xfer(8'h11, 8'hA2, "pp_pop");
      bus.bus_rdata = 8'h66;
      bus.bus_ready = 1'b1;
      port_id       = 8'h01;
      out_port      = 8'hB6;
      write_strobe  = 1'b1;
      tick();
      write_strobe  = 1'b0;
      bus.bus_ready = 1'b0;
      rd(8'h00, 1'b0, 8'h90, "st_pp_cnt2");
      rd(8'h02, 1'b0, 8'h66, "resp_pp");

      // refused push while full even with a concurrent pop
      out_w(8'h01, 8'hC1);
      out_w(8'h01, 8'hC2);
      expect_xfer(8'h11, 8'hA3, "fpp_pop");
      bus.bus_rdata = 8'h12;
      bus.bus_ready = 1'b1;
      port_id       = 8'h01;
      out_port      = 8'hD0;
      write_strobe  = 1'b1;
      tick();
      write_strobe  = 1'b0;
      bus.bus_ready = 1'b0;
      rd(8'h00, 1'b0, 8'h9C, "st_full_pp");

      // back-to-back drain in push order
      expect_xfer(8'h11, 8'hB6, "drain1");
      expect_xfer(8'h11, 8'hC1, "drain2");
      expect_xfer(8'h11, 8'hC2, "drain3");
      bus.bus_rdata = 8'h5E;
      bus.bus_ready = 1'b1;
      repeat (3) tick();
      bus.bus_ready = 1'b0;
      rd(8'h00, 1'b0, 8'h05, "st_drained");
      rd(8'h00, 1'b1, 8'h05, "st_clr2");
      rd(8'h00, 1'b0, 8'h01, "st_empty2");

      // reset mid-burst
      out_w(8'h00, 8'h21);
      out_w(8'h01, 8'hE1);
      out_w(8'h01, 8'hE2);
      expect_sig(K_VALID, 8'h01, "pre_rst_v");
      reset = 1'b0;
      tick();
      expect_sig(K_VALID, 8'h00, "mid_rst_v");
      expect_sig(K_CTRL,  8'h00, "mid_rst_c");
      reset = 1'b1;
      rd(8'h00, 1'b0, 8'h01, "st_after_rst");
      rd(8'h03, 1'b0, 8'h00, "addr_rst");
      rd(8'h02, 1'b0, 8'h00, "resp_rst");

      repeat (2) tick();
      cmp("xfer_left", 8'(xfer_q.size()), 8'h00);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pico_io_bridge.md
# pico_io_bridge

Peripheral-side I/O bridge directly downstream of the KCPSM6 processor top. Decodes the processor's `port_id`/`out_port`/`write_strobe`/`k_write_strobe`/`read_strobe` bus and queues OUTPUT transactions into a small FIFO drained by a valid/ready peripheral bus. Drives the processor's `in_port` with registered status, control readback and captured peripheral response data. Lets firmware post bursts of peripheral writes without stalling on slow devices.

## Interface
- `FIFO_DEPTH`, 4: transaction FIFO entries; power of two, 2..16.
- `CNT_W`, 5: width of the count field; must hold 0..FIFO_DEPTH.

- `clk`  in  1  system clock, same clock as the processor.
- `reset`  in  1  synchronous, active-low reset.
- `port_id`  in  8  processor port address.
- `out_port`  in  8  processor output data.
- `write_strobe`  in  1  OUTPUT strobe, 1 cycle.
- `k_write_strobe`  in  1  OUTPUTK strobe, 1 cycle; decodes on `port_id[3:0]` only.
- `read_strobe`  in  1  INPUT strobe, 1 cycle.
- `in_port`  out  8  registered read data to the processor.
- `bus_addr`  out  8  FIFO head address.
- `bus_data`  out  8  FIFO head data.
- `bus_valid`  out  1  FIFO non-empty.
- `bus_ready`  in  1  peripheral accepts the head this cycle.
- `bus_rdata`  in  8  peripheral response; valid on the transfer cycle.
- `ctrl_reg`  out  8  control register to the fabric.

## Operation
- Reset (`reset`=0 at a clk edge): FIFO empty, `bus_valid`=0, `bus_addr`/`bus_data`=0x00, `ctrl_reg`=0x00, `in_port`=0x00. Also clears the staging ADDR register, the RESP register and the overflow flag.
- Write decode on `write_strobe`:
  - 0x00: ADDR staging register <= `out_port`.
  - 0x01: push {ADDR, `out_port`} into the FIFO.
  - 0x02: `ctrl_reg` <= `out_port`.
  - Other ports: ignored.
- `k_write_strobe` with `port_id[3:0]`=0x2 writes `ctrl_reg`. All other OUTPUTK ports are ignored.
- Push with the FIFO full is refused, including when a pop occurs in the same cycle. A refused push sets the sticky `overflow` flag. FIFO contents are unchanged.
- Pop: when `bus_valid`&&`bus_ready`, the head is removed and `bus_rdata` is captured into RESP.
- Simultaneous push and pop when not full: both occur and the count is unchanged.
- Read map, sampled every cycle into `in_port` from the current `port_id`:
  - 0x00 STATUS: bit0 empty, bit1 full, bit2 overflow, bits[6:3] count, bit7 `bus_valid`.
  - 0x01: `ctrl_reg`.
  - 0x02: RESP.
  - 0x03: ADDR staging register.
  - Other ports: 0x00.
- `read_strobe` with `port_id`=0x00 clears `overflow` on the following edge. The value already registered in `in_port` is unaffected. If a refused push and the clear hit the same cycle, set wins.
- `bus_addr`/`bus_data` are combinational from FIFO head storage. They are stable while `bus_valid`=1 and `bus_ready`=0.

## Timing
- Register writes (ADDR, `ctrl_reg`) are visible one cycle after the strobe cycle.
- Push: `bus_valid` rises the cycle after the port-0x01 strobe. STATUS reflects the new count one cycle later via the registered `in_port`.
- `in_port` latency is 1 cycle from `port_id`. This meets KCPSM6 INPUT, which holds `port_id` for 2 cycles and samples with `read_strobe` in the second.
- Back-to-back pops: one pop per cycle while `bus_ready`=1.
- Count wraps never occur; pointers wrap modulo `FIFO_DEPTH`.
- Reset mid-transfer discards all queued entries. `bus_valid` is 0 the cycle after the reset edge.

## Structure
- Shared package `pico_io_pkg`:
  - Port address constants: PORT_ADDR, PORT_DATA, PORT_CTRL, PORT_RESP, PORT_STATUS, KPORT_CTRL.
  - STATUS bit-index constants.
- One sub-module `pico_io_fifo` holds the storage, pointers, count, full/empty flags and the push/pop interface. Parameterised by `FIFO_DEPTH` and entry width (16).
- The top contains the port decode, registers, overflow flag and read mux.

## Test plan
- Reset then read port 0x00 -> `in_port`=0x01 (empty). `bus_valid`=0, `ctrl_reg`=0x00.
- OUT 0x3C->0x00, OUT 0x5A->0x01 with `bus_ready`=0 -> next cycle `bus_valid`=1, `bus_addr`=0x3C, `bus_data`=0x5A. STATUS=0x88.
- 5 pushes with `bus_ready`=0 -> 5th refused. STATUS=0x26|0x80=0xA6 (full, overflow, count 4). Read of 0x00 with `read_strobe` -> next STATUS=0xA2.
- Full FIFO, `bus_ready`=1 with `bus_rdata`=0x77 for 1 cycle -> count 3. Read port 0x02 -> 0x77. Head advances in push order.
- OUTPUTK 0xE5 to port 0x12 -> `ctrl_reg`=0xE5. OUTPUTK to 0x13 -> unchanged.
- Push and pop in the same cycle at count 2 -> count stays 2. Assert `reset`=0 mid-burst -> `bus_valid`=0 and STATUS=0x01 after release.
